// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : cdb_arbiter_if
// Brief   : Producer-side request bus and CDB broadcast bus of cdb_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface cdb_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int ROB_W  = 5,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ROB_W-1:0]  req_tag;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    cdb_valid;
  logic [ROB_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]       cdb_data;
  logic [1:0]              cdb_src;
  logic [N_REQ*3-1:0]      fifo_count;

  modport master (
    output req_valid, req_tag, req_data,
    input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, fifo_count
  );

  modport slave (
    input  req_valid, req_tag, req_data,
    output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, fifo_count
  );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cdb_arbiter
// Brief   : Per-producer result FIFOs drained round-robin onto a registered CDB.
// Revision: 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
  parameter int N_REQ      = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int ROB_W      = 5,
  parameter int DATA_W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);
  localparam int                   C_PTR_W     = $clog2(FIFO_DEPTH);
  localparam int                   C_CNT_W     = C_PTR_W + 1;
  localparam logic [C_CNT_W-1:0]   C_FULL      = C_CNT_W'(FIFO_DEPTH);
  localparam logic [C_CNT_W-1:0]   C_CNT_ONE   = C_CNT_W'(1);
  localparam logic [C_PTR_W-1:0]   C_PTR_ONE   = C_PTR_W'(1);
  localparam logic [1:0]           C_LAST_INIT = 2'(N_REQ - 1);

  logic [ROB_W-1:0]   r_tag_mem  [N_REQ][FIFO_DEPTH];
  logic [DATA_W-1:0]  r_data_mem [N_REQ][FIFO_DEPTH];
  logic [C_PTR_W-1:0] r_wr_ptr   [N_REQ];
  logic [C_PTR_W-1:0] r_rd_ptr   [N_REQ];
  logic [C_CNT_W-1:0] r_count    [N_REQ];
  logic [1:0]         r_last;
  logic               r_cdb_valid;
  logic [ROB_W-1:0]   r_cdb_tag;
  logic [DATA_W-1:0]  r_cdb_data;
  logic [1:0]         r_cdb_src;

  logic [N_REQ-1:0]   w_ready;
  logic [N_REQ-1:0]   w_push;
  logic [N_REQ-1:0]   w_pop;
  logic               w_any;
  logic [1:0]         w_win;
  logic [ROB_W-1:0]   w_head_tag;
  logic [DATA_W-1:0]  w_head_data;

  // Ready deliberately ignores a same-cycle pop; tag-0 results complete the handshake but are dropped.
  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    assign w_ready[i] = rst && (r_count[i] < C_FULL);
    assign w_push[i]  = bus.req_valid[i] && w_ready[i] && !flush &&
                        (bus.req_tag[i*ROB_W +: ROB_W] != '0);
    assign w_pop[i]   = w_any && (w_win == 2'(i));
    assign bus.req_ready[i]          = w_ready[i];
    assign bus.fifo_count[i*3 +: 3]  = 3'(r_count[i]);
  end

  // Round-robin scan starting after the last grant; sees only pre-edge FIFO state.
  always_comb begin
    int idx;
    idx         = 0;
    w_any       = 1'b0;
    w_win       = '0;
    w_head_tag  = '0;
    w_head_data = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(r_last) + k) % N_REQ;
      if (!w_any && (r_count[idx] != '0)) begin
        w_any       = 1'b1;
        w_win       = 2'(idx);
        w_head_tag  = r_tag_mem[idx][r_rd_ptr[idx]];
        w_head_data = r_data_mem[idx][r_rd_ptr[idx]];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (w_push[i]) begin
        r_tag_mem[i][r_wr_ptr[i]]  <= bus.req_tag[i*ROB_W +: ROB_W];
        r_data_mem[i][r_wr_ptr[i]] <= bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
      r_last      <= C_LAST_INIT;
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
      r_cdb_src   <= '0;
    end else if (flush) begin
      for (int i = 0; i < N_REQ; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + C_PTR_ONE;
        if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + C_PTR_ONE;
        if (w_push[i] && !w_pop[i])      r_count[i] <= r_count[i] + C_CNT_ONE;
        else if (!w_push[i] && w_pop[i]) r_count[i] <= r_count[i] - C_CNT_ONE;
      end
      // Idle cycles drive tag 0 since consumers match tags without looking at valid.
      if (w_any) begin
        r_cdb_valid <= 1'b1;
        r_cdb_tag   <= w_head_tag;
        r_cdb_data  <= w_head_data;
        r_cdb_src   <= w_win;
        r_last      <= w_win;
      end else begin
        r_cdb_valid <= 1'b0;
        r_cdb_tag   <= '0;
        r_cdb_data  <= '0;
      end
    end
  end

  assign bus.cdb_valid = r_cdb_valid;
  assign bus.cdb_tag   = r_cdb_tag;
  assign bus.cdb_data  = r_cdb_data;
  assign bus.cdb_src   = r_cdb_src;
endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cdb_arbiter
// Brief   : Directed self-checking bench for cdb_arbiter (3 requesters, depth 4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;
  localparam int N_REQ      = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int ROB_W      = 5;
  localparam int DATA_W     = 32;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_REQ(N_REQ), .ROB_W(ROB_W), .DATA_W(DATA_W)) bus ();

  cdb_arbiter #(
    .N_REQ(N_REQ), .FIFO_DEPTH(FIFO_DEPTH), .ROB_W(ROB_W), .DATA_W(DATA_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  // Backpressure scenario: per-edge pushes and the expected CDB after that edge.
  logic [2:0] pv   [13] = '{3'b111, 3'b111, 3'b011, 3'b010, 3'b010, 3'b010, 3'b010,
                            3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
  int         ta   [13] = '{17, 18, 19, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int         tl   [13] = '{1, 2, 3, 4, 5, 6, 6, 0, 0, 0, 0, 0, 0};
  int         tbr  [13] = '{25, 26, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int         ev   [13] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int         etag [13] = '{0, 17, 1, 25, 18, 2, 26, 19, 3, 4, 5, 6, 0};
  int         esrc [13] = '{2, 0, 1, 2, 0, 1, 2, 0, 1, 1, 1, 1, 1};

  function automatic logic [31:0] dat(input int t);
    return 32'hC0DE_0000 | 32'(t);
  endfunction

  function automatic logic [8:0] cnt(input int a, input int l, input int b);
    return {3'(b), 3'(l), 3'(a)};
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] v, input int t0, input int t1, input int t2);
    bus.req_valid = v;
    bus.req_tag   = {5'(t2), 5'(t1), 5'(t0)};
    bus.req_data  = {dat(t2), dat(t1), dat(t0)};
  endtask

  task automatic chk_cdb(input string name, input int v, input int tag, input int src);
    check({name, "_valid"}, 64'(bus.cdb_valid), 64'(v));
    check({name, "_tag"},   64'(bus.cdb_tag),   64'(tag));
    check({name, "_data"},  64'(bus.cdb_data),  (v != 0) ? 64'(dat(tag)) : 64'd0);
    check({name, "_src"},   64'(bus.cdb_src),   64'(src));
  endtask

  initial begin
    drive(3'b000, 0, 0, 0);

    // Reset held two edges, then release.
    tick();
    tick();
    chk_cdb("reset", 0, 0, 0);
    check("reset_ready", 64'(bus.req_ready), 64'd0);
    check("reset_count", 64'(bus.fifo_count), 64'(cnt(0, 0, 0)));
    rst = 1'b1;
    #1;
    check("release_ready", 64'(bus.req_ready), 64'b111);

    // Single ALU push: broadcast appears after the second edge.
    drive(3'b001, 3, 0, 0);
    tick();
    drive(3'b000, 0, 0, 0);
    chk_cdb("single_e1", 0, 0, 0);
    check("single_count", 64'(bus.fifo_count), 64'(cnt(1, 0, 0)));
    tick();
    chk_cdb("single_e2", 1, 3, 0);
    check("single_count_drain", 64'(bus.fifo_count), 64'(cnt(0, 0, 0)));
    tick();
    chk_cdb("single_e3", 0, 0, 0);

    // Round-robin from a fresh reset; second batch pushed while the first drains.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    drive(3'b111, 1, 2, 3);
    tick();
    chk_cdb("rr_e0", 0, 0, 0);
    check("rr_count0", 64'(bus.fifo_count), 64'(cnt(1, 1, 1)));
    drive(3'b111, 4, 5, 6);
    tick();
    drive(3'b000, 0, 0, 0);
    chk_cdb("rr_t1", 1, 1, 0);
    check("rr_count1", 64'(bus.fifo_count), 64'(cnt(1, 2, 2)));
    for (int k = 2; k <= 6; k++) begin
      tick();
      chk_cdb($sformatf("rr_t%0d", k), 1, k, (k - 1) % 3);
    end
    tick();
    chk_cdb("rr_idle", 0, 0, 2);

    // Load/store FIFO fills while ALU and branch compete; the sixth push is held.
    for (int s = 0; s < 13; s++) begin
      drive(pv[s], ta[s], tl[s], tbr[s]);
      tick();
      chk_cdb($sformatf("bp_e%0d", s + 1), ev[s], etag[s], esrc[s]);
      if (s == 4) begin
        check("bp_full_ready", 64'(bus.req_ready), 64'b101);
        check("bp_full_count", 64'(bus.fifo_count), 64'(cnt(1, 4, 1)));
      end
      if (s == 5) begin
        check("bp_held_ready", 64'(bus.req_ready), 64'b111);
        check("bp_held_count", 64'(bus.fifo_count), 64'(cnt(1, 3, 1)));
      end
      if (s == 6) check("bp_accept_count", 64'(bus.fifo_count), 64'(cnt(1, 4, 0)));
    end
    drive(3'b000, 0, 0, 0);

    // Zero tag: handshake completes, nothing queued or broadcast.
    drive(3'b001, 0, 0, 0);
    bus.req_data = {dat(0), dat(0), 32'h0000_00FF};
    check("zero_ready", 64'(bus.req_ready[0]), 64'd1);
    tick();
    drive(3'b000, 0, 0, 0);
    check("zero_count", 64'(bus.fifo_count), 64'(cnt(0, 0, 0)));
    chk_cdb("zero_e1", 0, 0, 1);
    tick();
    chk_cdb("zero_e2", 0, 0, 1);

    // Flush with entries queued and a push of tag 10 in flight.
    drive(3'b001, 7, 0, 0);
    tick();
    check("fl_count1", 64'(bus.fifo_count), 64'(cnt(1, 0, 0)));
    drive(3'b101, 8, 0, 9);
    tick();
    chk_cdb("fl_pre", 1, 7, 0);
    check("fl_count2", 64'(bus.fifo_count), 64'(cnt(1, 0, 1)));
    flush = 1'b1;
    drive(3'b001, 10, 0, 0);
    tick();
    flush = 1'b0;
    drive(3'b000, 0, 0, 0);
    chk_cdb("fl_post", 0, 0, 0);
    check("fl_count_post", 64'(bus.fifo_count), 64'(cnt(0, 0, 0)));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_cdb($sformatf("fl_quiet%0d", k), 0, 0, 0);
    end

    // Reset in the middle of traffic.
    drive(3'b111, 11, 12, 13);
    tick();
    drive(3'b001, 14, 0, 0);
    tick();
    drive(3'b000, 0, 0, 0);
    chk_cdb("mr_pre", 1, 12, 1);
    check("mr_count_pre", 64'(bus.fifo_count), 64'(cnt(2, 0, 1)));
    rst = 1'b0;
    #1;
    check("mr_ready_low", 64'(bus.req_ready), 64'd0);
    tick();
    chk_cdb("mr_reset", 0, 0, 0);
    check("mr_count", 64'(bus.fifo_count), 64'(cnt(0, 0, 0)));
    rst = 1'b1;
    #1;
    check("mr_ready_back", 64'(bus.req_ready), 64'b111);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk_cdb($sformatf("mr_quiet%0d", k), 0, 0, 0);
    end
    drive(3'b001, 21, 0, 0);
    tick();
    drive(3'b000, 0, 0, 0);
    tick();
    chk_cdb("mr_after", 1, 21, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
